gpio_capture: RTL
=================

GPIO_CAPTURE -- requirements
Module: gpio_capture

Interface
REQ-001 Parameters SHALL be, one per line:
- FRAME_LEN, 152100, bytes per frame (390x390 image)
- DEPTH, 16, FIFO entries (power of two, >= 2)
REQ-002 Ports SHALL be, one per line (clock and reset first):
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- gpio_i  in  8  processor GPIO data byte
- gpio_en_i  in  1  processor GPIO strobe; falling edge marks a valid byte
- arm_i  in  1  one-cycle pulse; starts frame capture
- m_data_o  out  8  FIFO head byte
- m_valid_o  out  1  m_data_o valid
- m_ready_i  in  1  downstream accepts byte
- count_o  out  18  bytes pushed in current frame
- done_o  out  1  frame complete and FIFO drained
- overflow_o  out  1  sticky: byte lost to full FIFO
REQ-003 The block SHALL use one clock (clk) and a synchronous, active-high reset (rst); no other clock or asynchronous reset.

Function
REQ-004 gpio_i and gpio_en_i SHALL be registered each cycle into gpio_q/en_q; fall = en_q & ~gpio_en_i.
REQ-005 On fall, the captured byte SHALL be gpio_q (value from the last cycle gpio_en_i was high).
REQ-006 FSM states: IDLE, CAPTURE, DRAIN, DONE.
REQ-007 IDLE: falls ignored; arm_i -> CAPTURE with count_o cleared to 0 and overflow_o cleared.
REQ-008 CAPTURE: each fall pushes one byte if FIFO not full (or full with pop in same cycle); count_o increments by 1 per push.
REQ-009 Fall while full and no same-cycle pop SHALL drop the byte, not increment count_o, and set overflow_o.
REQ-010 When a push makes count_o equal FRAME_LEN, next state SHALL be DRAIN; falls in DRAIN/DONE SHALL be ignored.
REQ-011 DRAIN -> DONE on the cycle the FIFO becomes empty; done_o = 1 exactly in DONE.
REQ-012 DONE: arm_i -> CAPTURE (new frame, count_o=0, overflow_o cleared); arm_i in CAPTURE/DRAIN SHALL be ignored.
REQ-013 FIFO: m_valid_o = not empty; pop when m_valid_o & m_ready_i; m_data_o stable while m_valid_o & ~m_ready_i.
REQ-014 Push-to-m_valid_o latency SHALL be 1 cycle after the fall is detected (2 cycles after gpio_en_i first sampled low).
REQ-015 Simultaneous push and pop SHALL leave occupancy unchanged, in all FIFO states including full.
REQ-016 FIFO pointers SHALL wrap modulo DEPTH; occupancy tracked with log2(DEPTH)+1 bits.
REQ-017 count_o SHALL saturate at FRAME_LEN; never wraps.

Reset
REQ-018 rst SHALL force: state IDLE, FIFO empty, m_valid_o=0, m_data_o=0, count_o=0, done_o=0, overflow_o=0, en_q=0, gpio_q=0.
REQ-019 rst mid-frame SHALL discard FIFO contents and count; no byte is pushed on the cycle rst is high.
REQ-020 A gpio_en_i high-to-low transition spanning reset release SHALL NOT produce a push (en_q reset to 0).

Structure
REQ-021 A shared package SHALL hold the FSM state enum and FRAME_LEN default constant.
REQ-022 The FIFO SHALL be a sub-module named gpio_fifo (DEPTH parameter, push/pop/full/empty ports).
REQ-023 Target size: 120-400 lines of RTL total.

Verification
REQ-024 Reset, arm, 3 strobes with bytes 0xA5,0x3C,0xFF, m_ready_i=1 -> m_data_o sequence A5,3C,FF; count_o=3.
REQ-025 m_ready_i=0, 17 strobes with DEPTH=16 -> 16 bytes held, overflow_o=1, count_o=16; then drain gives first 16 bytes in order.
REQ-026 FRAME_LEN=4, 6 strobes -> exactly 4 bytes delivered, state DRAIN then done_o=1 one cycle after the last pop; extra strobes ignored.
REQ-027 FIFO full, fall coincident with pop -> byte accepted, overflow_o stays 0, occupancy remains 16.
REQ-028 rst asserted after 5 of 10 pushes -> m_valid_o=0, count_o=0 next cycle; strobes before arm_i not captured.
REQ-029 Full frame FRAME_LEN=152100 from processor model, m_ready_i random -> 152100 bytes match golden file, done_o=1, overflow_o=0.

Source files
------------

// File: rtl/gpio_capture_pkg.sv
// Shared types and constants for the GPIO frame capture block.
// Holds the capture FSM state encoding and the default frame length.
package gpio_capture_pkg;

   // 390 x 390 image, one byte per pixel
   localparam int FRAME_LEN_DEF = 152100;

   // Width of the per-frame byte counter
   localparam int CNT_W = 18;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_DRAIN   = 2'd2,
      ST_DONE    = 2'd3
   } state_e;

endpackage

// File: rtl/gpio_fifo.sv
// Byte FIFO between the GPIO capture logic and the downstream consumer.
// Ports: clk, rst (sync, active-high), push_i/data_i write side,
//        pop_i/data_o read side, full_o, empty_o, level_o occupancy.
module gpio_fifo
   import gpio_capture_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int W     = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push_i,
   input  logic [W-1:0]               data_i,
   input  logic                       pop_i,
   output logic [W-1:0]               data_o,
   output logic                       full_o,
   output logic                       empty_o,
   output logic [$clog2(DEPTH):0]     level_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q;
   logic [AW-1:0] rd_q;
   logic [AW:0]   lvl_q;
   logic          do_push;
   logic          do_pop;

   assign empty_o = (lvl_q == '0);
   assign full_o  = (lvl_q == FULL_LVL);
   assign level_o = lvl_q;

   // A pop frees the head slot in the same cycle, so a full FIFO
   // can still take a write when it is also being read.
   assign do_pop  = pop_i & ~empty_o;
   assign do_push = push_i & (~full_o | do_pop);

   // Forced to zero when empty so the output is defined out of reset
   assign data_o = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= data_i;
      end
   end

   // Pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         lvl_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   lvl_q <= lvl_q + 1'b1;
            2'b01:   lvl_q <= lvl_q - 1'b1;
            default: lvl_q <= lvl_q;
         endcase
      end
   end

endmodule

// File: rtl/gpio_capture.sv
// Captures bytes strobed by a processor over GPIO into a frame FIFO.
// Ports: clk, rst; gpio_i/gpio_en_i strobe input; arm_i frame start;
//        m_data_o/m_valid_o/m_ready_i stream out; count_o, done_o, overflow_o.
module gpio_capture
   import gpio_capture_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF,
   parameter int DEPTH     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       gpio_i,
   input  logic             gpio_en_i,
   input  logic             arm_i,
   output logic [7:0]       m_data_o,
   output logic             m_valid_o,
   input  logic             m_ready_i,
   output logic [CNT_W-1:0] count_o,
   output logic             done_o,
   output logic             overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_LEN);
   localparam logic [AW:0]      ONE_LVL  = (AW+1)'(1);

   state_e           state_q;
   state_e           state_d;
   logic [7:0]       gpio_q;
   logic             en_q;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             ovf_q;
   logic             ovf_d;

   logic             fall;
   logic             pop;
   logic             push;
   logic             drop;
   logic             arm_ok;
   logic             full;
   logic             empty;
   logic [AW:0]      level;

   // Input registers; en_q resets low so a strobe that falls across
   // reset release is not mistaken for a byte.
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_q <= '0;
         en_q   <= 1'b0;
      end else begin
         gpio_q <= gpio_i;
         en_q   <= gpio_en_i;
      end
   end

   assign fall   = en_q & ~gpio_en_i;
   assign pop    = ~empty & m_ready_i;
   assign arm_ok = arm_i & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign push   = (state_q == ST_CAPTURE) & fall & (~full | pop);
   assign drop   = (state_q == ST_CAPTURE) & fall & full & ~pop;

   // State register
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (arm_ok) state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (push && count_q == LAST_CNT) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            // No pushes happen here, so a pop at level 1 empties it
            if (empty || (pop && level == ONE_LVL)) state_d = ST_DONE;
         end
         ST_DONE: begin
            if (arm_ok) state_d = ST_CAPTURE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs and frame counters
   always_comb begin
      count_d = count_q;
      ovf_d   = ovf_q;
      done_o  = (state_q == ST_DONE);
      unique case (1'b1)
         arm_ok: begin
            count_d = '0;
            ovf_d   = 1'b0;
         end
         push: begin
            if (count_q != FULL_CNT) count_d = count_q + 1'b1;
         end
         drop: begin
            ovf_d = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   gpio_fifo #(
      .DEPTH (DEPTH),
      .W     (8)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .data_i  (gpio_q),
      .pop_i   (pop),
      .data_o  (m_data_o),
      .full_o  (full),
      .empty_o (empty),
      .level_o (level)
   );

   assign m_valid_o  = ~empty;
   assign count_o    = count_q;
   assign overflow_o = ovf_q;

endmodule
